// File: rtl/adder_pkg.sv
// adder_pkg: shared FSM state encoding and chunk-counter width helper for chunked_adder.
package adder_pkg;
    typedef enum logic [1:0] {IDLE, RUN, HOLD} state_t;

    function automatic int cnt_width(input int n);
        return (n > 1) ? $clog2(n) : 1;
    endfunction
endpackage

// File: rtl/chunk_adder.sv
// chunk_adder: CHUNK-bit ripple slice reporting carry-out and the carry into its MSB.
module chunk_adder #(
    parameter int CHUNK = 4
) (
    input  logic [CHUNK-1:0] a,
    input  logic [CHUNK-1:0] b,
    input  logic             cin,
    output logic [CHUNK-1:0] s,
    output logic             cout,
    output logic             c_msb
);
    logic [CHUNK:0] sum;

    always_comb begin
        sum   = {1'b0, a} + {1'b0, b} + (CHUNK+1)'(cin);
        s     = sum[CHUNK-1:0];
        cout  = sum[CHUNK];
        c_msb = a[CHUNK-1] ^ b[CHUNK-1] ^ sum[CHUNK-1];
    end
endmodule

// File: rtl/chunked_adder.sv
// chunked_adder: multi-cycle add/subtract processing CHUNK bits per clock, LSB first,
// with a valid/ready handshake on both sides.
module chunked_adder
    import adder_pkg::*;
#(
    parameter int WIDTH = 16,
    parameter int CHUNK = 4
) (
    input  logic             clk,
    input  logic             rst_n,
    input  logic             in_valid,
    output logic             in_ready,
    input  logic [WIDTH-1:0] a,
    input  logic [WIDTH-1:0] b,
    input  logic             cin,
    input  logic             sub,
    output logic             out_valid,
    input  logic             out_ready,
    output logic [WIDTH-1:0] s,
    output logic             cout,
    output logic             ovf
);
    localparam int NCHUNK = WIDTH / CHUNK;
    localparam int KW = cnt_width(NCHUNK);

    state_t state, next;
    logic [KW-1:0] k;
    logic [WIDTH-1:0] a_r, b_r;
    logic carry, last, c_out, c_msb;
    logic [CHUNK-1:0] c_sum;

    assign last = k == KW'(NCHUNK - 1);
    assign in_ready = state == IDLE;
    assign out_valid = state == HOLD;

    chunk_adder #(.CHUNK(CHUNK)) u_chunk (
        .a(a_r[int'(k)*CHUNK +: CHUNK]),
        .b(b_r[int'(k)*CHUNK +: CHUNK]),
        .cin(carry),
        .s(c_sum),
        .cout(c_out),
        .c_msb(c_msb)
    );

    always_comb begin
        next = state;
        if (state == IDLE && in_valid) next = RUN;
        if (state == RUN && last) next = HOLD;
        if (state == HOLD && out_ready) next = IDLE;
    end

    always_ff @(posedge clk or negedge rst_n)
        if (!rst_n) state <= IDLE;
        else state <= next;

    // Subtraction is folded in at capture: store ~b and ~cin so RUN only ever adds.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            a_r   <= '0;
            b_r   <= '0;
            carry <= 1'b0;
            k     <= '0;
            s     <= '0;
            cout  <= 1'b0;
            ovf   <= 1'b0;
        end else if (state == IDLE && in_valid) begin
            a_r   <= a;
            b_r   <= sub ? ~b : b;
            carry <= cin ^ sub;
            k     <= '0;
        end else if (state == RUN) begin
            s[int'(k)*CHUNK +: CHUNK] <= c_sum;
            carry <= c_out;
            k     <= last ? '0 : k + 1'b1;
            if (last) begin
                cout <= c_out;
                ovf  <= c_out ^ c_msb;
            end
        end
    end
endmodule

// File: tb/tb_chunked_adder.sv
// tb_chunked_adder: table-driven vectors with a scoreboard queue; CHUNK overridable for the 1-cycle build.
module tb_chunked_adder #(
    parameter int CHUNK = 4
);
    localparam int WIDTH = 16;
    localparam int NCHUNK = WIDTH / CHUNK;

    logic clk = 1'b0, rst_n = 1'b0, in_valid = 1'b0, out_ready = 1'b0, cin = 1'b0, sub = 1'b0;
    logic [WIDTH-1:0] a = '0, b = '0, s;
    logic in_ready, out_valid, cout, ovf;
    int tests = 0, fails = 0;

    typedef struct {
        logic [15:0] s;
        logic cout;
        logic ovf;
    } exp_t;

    typedef struct {
        logic [15:0] a;
        logic [15:0] b;
        logic cin;
        logic sub;
        logic [15:0] s;
        logic cout;
        logic ovf;
        int hold;
        bit noise;
    } vec_t;

    exp_t q[$];

    chunked_adder #(.WIDTH(WIDTH), .CHUNK(CHUNK)) dut (
        .clk(clk), .rst_n(rst_n), .in_valid(in_valid), .in_ready(in_ready),
        .a(a), .b(b), .cin(cin), .sub(sub), .out_valid(out_valid),
        .out_ready(out_ready), .s(s), .cout(cout), .ovf(ovf)
    );

    always #5 clk = ~clk;

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        tests++;
        if (act !== exp) begin
            fails++;
            $display("FAIL %s: got %h expected %h", name, act, exp);
        end
    endtask

    function automatic exp_t model(input logic [15:0] x, input logic [15:0] y, input logic c, input logic sb);
        exp_t m;
        logic [16:0] r;
        int sr;
        r = sb ? {1'b0, x} - {1'b0, y} - 17'(c) : {1'b0, x} + {1'b0, y} + 17'(c);
        sr = sb ? int'($signed(x)) - int'($signed(y)) - int'(c)
                : int'($signed(x)) + int'($signed(y)) + int'(c);
        m.s = r[15:0];
        m.cout = sb ? ~r[16] : r[16];
        m.ovf = (sr > 32767) || (sr < -32768);
        return m;
    endfunction

    task automatic do_op(input vec_t v);
        int n;
        exp_t e;
        n = 0;
        while (!in_ready && n < 50) begin
            @(negedge clk);
            n++;
        end
        check("ready_wait", in_ready, 1);
        a = v.a; b = v.b; cin = v.cin; sub = v.sub; in_valid = 1'b1;
        e.s = v.s; e.cout = v.cout; e.ovf = v.ovf;
        q.push_back(e);
        @(posedge clk);
        @(negedge clk);
        in_valid = 1'b0;
        if (v.noise) begin
            a = ~v.a; b = 16'h5A5A; cin = ~v.cin; sub = ~v.sub; in_valid = 1'b1;
        end
        n = 0;
        while (!out_valid && n < NCHUNK + 5) begin
            @(negedge clk);
            n++;
        end
        check("latency", n, NCHUNK);
        check("out_valid", out_valid, 1);
        if (out_valid) begin
            if (q.size() == 0) check("sb_empty", 0, 1);
            else begin
                e = q.pop_front();
                check("s", s, e.s);
                check("cout", cout, e.cout);
                check("ovf", ovf, e.ovf);
                check("in_ready_hold", in_ready, 0);
                for (int i = 0; i < v.hold; i++) begin
                    @(negedge clk);
                    check("hold_valid", out_valid, 1);
                    check("hold_s", s, e.s);
                    check("hold_flags", {cout, ovf}, {e.cout, e.ovf});
                end
                out_ready = 1'b1;
                @(negedge clk);
                out_ready = 1'b0;
                in_valid = 1'b0;
                check("post_ready", in_ready, 1);
                check("post_valid", out_valid, 0);
                check("idle_s", s, e.s);
                check("idle_flags", {cout, ovf}, {e.cout, e.ovf});
            end
        end
        in_valid = 1'b0;
    endtask

    initial begin
        vec_t tab[6];
        vec_t v;
        exp_t m;
        tab[0] = '{16'h000F, 16'h0001, 1'b0, 1'b0, 16'h0010, 1'b0, 1'b0, 0, 1'b0};
        tab[1] = '{16'hFFFF, 16'hFFFF, 1'b1, 1'b0, 16'hFFFF, 1'b1, 1'b0, 0, 1'b0};
        tab[2] = '{16'h7FFF, 16'h0001, 1'b0, 1'b0, 16'h8000, 1'b0, 1'b1, 5, 1'b1};
        tab[3] = '{16'h0005, 16'h0007, 1'b0, 1'b1, 16'hFFFE, 1'b0, 1'b0, 0, 1'b1};
        tab[4] = '{16'h8000, 16'h0001, 1'b0, 1'b1, 16'h7FFF, 1'b1, 1'b1, 2, 1'b0};
        tab[5] = '{16'h0000, 16'h0000, 1'b1, 1'b1, 16'hFFFF, 1'b0, 1'b0, 0, 1'b0};

        #2;
        check("rst_s", s, 0);
        check("rst_flags", {cout, ovf}, 0);
        check("rst_valid", out_valid, 0);
        check("rst_ready", in_ready, 1);
        @(negedge clk);
        rst_n = 1'b1;
        @(negedge clk);

        foreach (tab[i]) do_op(tab[i]);

        for (int i = 0; i < 8; i++) begin
            v.a = 16'($urandom); v.b = 16'($urandom);
            v.cin = 1'($urandom); v.sub = 1'($urandom);
            m = model(v.a, v.b, v.cin, v.sub);
            v.s = m.s; v.cout = m.cout; v.ovf = m.ovf;
            v.hold = int'($urandom_range(0, 3)); v.noise = 1'($urandom);
            do_op(v);
        end

        // Abort an operation at chunk index 2, then confirm a clean restart.
        a = 16'h1234; b = 16'h1111; cin = 1'b0; sub = 1'b0; in_valid = 1'b1;
        @(posedge clk);
        @(negedge clk);
        in_valid = 1'b0;
        @(posedge clk);
        @(posedge clk);
        #1;
        rst_n = 1'b0;
        #1;
        check("mid_rst_s", s, 0);
        check("mid_rst_flags", {cout, ovf}, 0);
        check("mid_rst_valid", out_valid, 0);
        check("mid_rst_ready", in_ready, 1);
        @(negedge clk);
        rst_n = 1'b1;
        @(negedge clk);
        check("rel_ready", in_ready, 1);
        v = '{16'h0003, 16'h0004, 1'b0, 1'b0, 16'h0007, 1'b0, 1'b0, 1, 1'b0};
        do_op(v);
        check("sb_drained", q.size(), 0);

        $display("[TB] %0d tests run, %0d failed", tests, fails);
        $finish;
    end
endmodule

// File: doc/chunked_adder.md
CHUNKED_ADDER -- requirements
Module: chunked_adder

Interface
REQ-001 Parameter WIDTH, default 16, operand and result width in bits.
REQ-002 Parameter CHUNK, default 4, bits added per clock cycle; WIDTH SHALL be an integer multiple of CHUNK, and NCHUNK = WIDTH/CHUNK.
REQ-003 clk  input  1  single clock, all state updates on the rising edge.
REQ-004 rst_n  input  1  asynchronous active-low reset.
REQ-005 in_valid  input  1  operands and mode are valid.
REQ-006 in_ready  output  1  block can accept a new operation.
REQ-007 a  input  WIDTH  first operand.
REQ-008 b  input  WIDTH  second operand.
REQ-009 cin  input  1  carry-in (add) or borrow-in (subtract).
REQ-010 sub  input  1  0 = add, 1 = subtract.
REQ-011 out_valid  output  1  result is valid.
REQ-012 out_ready  input  1  consumer accepts the result.
REQ-013 s  output  WIDTH  sum or difference.
REQ-014 cout  output  1  carry-out; for subtract, 1 = no borrow.
REQ-015 ovf  output  1  two's-complement signed overflow.

Function
REQ-016 The FSM SHALL have exactly three states: IDLE, RUN and HOLD.
REQ-017 in_ready SHALL be 1 only in IDLE, and out_valid SHALL be 1 only in HOLD.
REQ-018 In IDLE, in_valid=1 SHALL capture a, b, cin and sub, clear chunk index k to 0, and move to RUN.
REQ-019 The operation SHALL be: add = a + b + cin; subtract = a + ~b + ~cin, i.e. a - b - cin.
REQ-020 In RUN, each cycle SHALL add chunk k (bits k*CHUNK +: CHUNK) together with the registered carry, write the result into s, update the carry, and increment k; chunks are processed LSB first.
REQ-021 When k = NCHUNK-1 completes, the FSM SHALL latch cout (final carry) and ovf (carry into MSB XOR carry out of MSB), then enter HOLD.
REQ-022 Latency: out_valid SHALL first be observed exactly NCHUNK cycles after the accepting edge.
REQ-023 s, cout and ovf SHALL be stable throughout HOLD, including while out_ready=0 for any number of cycles.
REQ-024 In HOLD, out_ready=1 SHALL return the FSM to IDLE, so in_ready=1 on the next cycle; no new operation is accepted in the same cycle as the result handshake.
REQ-025 In IDLE, s, cout and ovf SHALL retain the last result.
REQ-026 In RUN and HOLD, in_valid SHALL be ignored and the captured operands SHALL NOT change.
REQ-027 When CHUNK = WIDTH, the block SHALL degenerate to 1-cycle latency with identical results.
REQ-028 out_ready SHALL be ignored outside HOLD.

Reset
REQ-029 rst_n=0 SHALL immediately force: state IDLE, k=0, carry=0, s=0, cout=0, ovf=0, out_valid=0, in_ready=1.
REQ-030 Reset asserted in the middle of RUN or HOLD SHALL abandon the operation with no result handshake; the first cycle after release SHALL be IDLE.

Structure
REQ-031 The FSM state encoding and the helper for the k counter width ($clog2(NCHUNK), minimum 1) SHALL live in the shared package adder_pkg.
REQ-032 Per-chunk addition SHALL use one sub-module, chunk_adder, with parameter CHUNK and ports a, b, cin, s, cout, c_msb (carry into the MSB); the top level instantiates it exactly once.

Verification
REQ-033 The bench SHALL cover, with WIDTH=16 and CHUNK=4:
- add 0x000F + 0x0001, cin=0 -> s=0x0010, cout=0, ovf=0, out_valid 4 cycles after accept.
- add 0xFFFF + 0xFFFF, cin=1 -> s=0xFFFF, cout=1, ovf=0.
- add 0x7FFF + 0x0001, cin=0 -> s=0x8000, cout=0, ovf=1.
- subtract 0x0005 - 0x0007, cin=0 -> s=0xFFFE, cout=0, ovf=0.
- out_ready held at 0 for 5 cycles in HOLD -> outputs stable; in_valid pulses during RUN/HOLD are ignored.
- rst_n pulsed low during RUN at k=2 -> all outputs 0 and in_ready=1 at once; a following 0x0003 + 0x0004 -> s=0x0007.
REQ-034 A second build with CHUNK=16 SHALL reproduce all the above results with 1-cycle latency.
